// File: rtl/seqdet_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// Optional match counter is enabled by defining SEQDET_COUNT_EN.
package seqdet_pkg;

    localparam int SEQDET_PAT_W_DEF = 8;
    localparam int SEQDET_CNT_W_DEF = 16;

    // Out of reset the detector compares the full history width.
    localparam int SEQDET_RST_LEN = SEQDET_PAT_W_DEF;

    // Width needed to hold a length or fill count in the range 0..pat_w.
    function automatic int seqdet_len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // FILLING: not enough history yet; ARMED: the next accepted bit can complete a match.
    typedef enum logic {
        SD_FILLING = 1'b0,
        SD_ARMED   = 1'b1
    } seqdet_phase_e;

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear and increment in the
// same cycle restart the count at 1 so that the coincident event is kept.
module seqdet_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q, q_d;

    // Next count: clear wins, otherwise count up until all-ones.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = W'(inc);
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + W'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector (1..PAT_W bit patterns,
// overlapping or non-overlapping). Define SEQDET_COUNT_EN to build the
// saturating match counter behind match_cnt/cnt_clr.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter  int PAT_W = SEQDET_PAT_W_DEF,
    parameter  int CNT_W = SEQDET_CNT_W_DEF,
    localparam int LW    = seqdet_len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LW-1:0]    len_in,
    input  logic             overlap_in,
    input  logic             cnt_clr,
    output logic             data_out,
    output logic [CNT_W-1:0] match_cnt
);

    // Reset length always tracks the instantiated width.
    localparam logic [LW-1:0] RST_LEN  = LW'(PAT_W);
    localparam logic [LW-1:0] FILL_MAX = LW'(PAT_W);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    fill_q, fill_d;
    logic             ovl_q, ovl_d;
    logic             out_q, out_d;

    logic [LW-1:0]    len_clamp;
    logic [PAT_W:0]   win;
    logic [PAT_W:0]   mask;
    logic [LW:0]      fill_p1;
    logic             hit;
    seqdet_phase_e    phase;

    // Clamp the requested length into 1..PAT_W.
    always_comb begin
        len_clamp = len_in;
        if (len_in == '0) begin
            len_clamp = LW'(1);
        end else if (len_in > FILL_MAX) begin
            len_clamp = FILL_MAX;
        end
    end

    // Window select: only the low len bits of {hist, data_in} take part.
    always_comb begin
        mask = '0;
        for (int i = 0; i <= PAT_W; i++) begin
            mask[i] = (32'(i) < 32'(len_q));
        end
    end

    // Phase and match decision for the bit currently on data_in.
    always_comb begin
        fill_p1 = {1'b0, fill_q} + (LW+1)'(1);
        phase   = (fill_p1 >= {1'b0, len_q}) ? SD_ARMED : SD_FILLING;
        win     = {hist_q, data_in};
        hit     = (phase == SD_ARMED) && (((win ^ {1'b0, pat_q}) & mask) == '0);
    end

    // Next state: config load beats an accepted bit; idle cycles hold.
    always_comb begin
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        out_d  = 1'b0;
        if (cfg_load) begin
            pat_d  = pat_in;
            len_d  = len_clamp;
            ovl_d  = overlap_in;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = win[PAT_W-1:0];
            out_d  = hit;
            if (hit && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + LW'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_q  <= '0;
            len_q  <= RST_LEN;
            ovl_q  <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= out_d;
        end
    end

    assign data_out = out_q;

`ifdef SEQDET_COUNT_EN
    logic acc_hit;
    assign acc_hit = in_valid && !cfg_load && hit;

    seqdet_sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (acc_hit),
        .clr (cnt_clr),
        .q   (match_cnt)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed + randomized bench for seq_detector_param against a bit-list
// reference model. Counter checks adapt to SEQDET_COUNT_EN.
module tb_seq_detector_param;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LW    = $clog2(PAT_W + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             data_in;
    logic             in_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] pat_in;
    logic [LW-1:0]    len_in;
    logic             overlap_in;
    logic             cnt_clr;
    logic             data_out;
    logic [CNT_W-1:0] match_cnt;

    seq_detector_param #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .cfg_load   (cfg_load),
        .pat_in     (pat_in),
        .len_in     (len_in),
        .overlap_in (overlap_in),
        .cnt_clr    (cnt_clr),
        .data_out   (data_out),
        .match_cnt  (match_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    // Reference model: the list of bits received since the last reset,
    // reload or non-overlap match, plus the latched configuration.
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    bit               m_bits[$];
    int               m_cnt;
    bit               exp_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit d, input bit ld,
                        input logic [PAT_W-1:0] p, input int l, input bit o,
                        input bit clr);
        bit hit;
        int n;
        rst        = r;
        in_valid   = v;
        data_in    = d;
        cfg_load   = ld;
        pat_in     = p;
        len_in     = l[LW-1:0];
        overlap_in = o;
        cnt_clr    = clr;
        hit        = 1'b0;
        if (!r) begin
            m_pat = '0; m_len = PAT_W; m_ovl = 1'b1;
            m_bits.delete(); m_cnt = 0;
        end else if (ld) begin
            m_pat = p;
            m_len = (l == 0) ? 1 : ((l > PAT_W) ? PAT_W : l);
            m_ovl = o;
            m_bits.delete();
            if (clr) m_cnt = 0;
        end else begin
            if (v) begin
                m_bits.push_back(d);
                if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
                n   = m_bits.size();
                hit = (n >= m_len);
                for (int k = 0; k < m_len; k++)
                    if (hit && (m_bits[n-1-k] != m_pat[k])) hit = 1'b0;
                if (hit && !m_ovl) m_bits.delete();
            end
            if (clr)                     m_cnt = hit ? 1 : 0;
            else if (hit && m_cnt < CMAX) m_cnt++;
        end
        exp_out = hit;
        @(posedge clk);
        #1;
        if (data_out === 1'b1) pulses++;
        chk("data_out", 32'(data_out), 32'(exp_out));
`ifdef SEQDET_COUNT_EN
        chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
`else
        chk("match_cnt_tied", 32'(match_cnt), 32'd0);
`endif
    endtask

    // Shorthands: accepted bit, idle cycle, reconfigure.
    task automatic bitin(input bit d);
        step(1, 1, d, 0, '0, 0, 0, 0);
    endtask
    task automatic idle();
        step(1, 0, 0, 0, '0, 0, 0, 0);
    endtask
    task automatic cfg(input logic [PAT_W-1:0] p, input int l, input bit o);
        step(1, 0, 0, 1, p, l, o, 0);
    endtask

    initial begin
        bit stream[8];
        bit gap_pat[5];
        logic [PAT_W-1:0] a5;
        stream  = '{1, 0, 1, 1, 0, 1, 1, 0};
        gap_pat = '{1, 0, 1, 1, 0};
        a5      = 8'hA5;

        // Reset state
        step(0, 0, 0, 0, '0, 0, 0, 0);
        step(0, 1, 1, 1, '1, 3, 0, 1);
        chk("reset_out", 32'(data_out), 32'd0);

        // Overlapping detection of 10110
        cfg(8'b10110, 5, 1);
        step(1, 0, 0, 0, '0, 0, 0, 1);
        pulses = 0;
        foreach (stream[i]) bitin(stream[i]);
        chk("ovl_pulses", 32'(pulses), 32'd2);
`ifdef SEQDET_COUNT_EN
        chk("ovl_cnt", 32'(match_cnt), 32'd2);
`endif

        // Non-overlapping detection, same stream
        cfg(8'b10110, 5, 0);
        step(1, 0, 0, 0, '0, 0, 0, 1);
        pulses = 0;
        foreach (stream[i]) bitin(stream[i]);
        chk("novl_pulses", 32'(pulses), 32'd1);
`ifdef SEQDET_COUNT_EN
        chk("novl_cnt", 32'(match_cnt), 32'd1);
`endif

        // Random idle gaps inside the pattern
        cfg(8'b10110, 5, 1);
        pulses = 0;
        foreach (gap_pat[i]) begin
            repeat ($urandom_range(0, 3)) idle();
            bitin(gap_pat[i]);
        end
        chk("gap_last_pulse", 32'(data_out), 32'd1);
        repeat (3) idle();
        chk("gap_pulses", 32'(pulses), 32'd1);

        // Mid-stream reload discards the concurrent bit
        cfg(8'b10110, 5, 1);
        bitin(1); bitin(0); bitin(1); bitin(1);
        step(1, 1, 0, 1, 8'b011, 3, 1, 0);
        chk("reload_no_pulse", 32'(data_out), 32'd0);
        pulses = 0;
        bitin(0); bitin(1);
        chk("reload_early", 32'(pulses), 32'd0);
        bitin(1);
        chk("reload_hit", 32'(data_out), 32'd1);

        // Length 0 clamps to 1
        cfg(8'b1, 0, 1);
        pulses = 0;
        bitin(1); bitin(1); bitin(0); bitin(1);
        chk("len0_pulses", 32'(pulses), 32'd3);

        // Length 15 clamps to 8
        cfg(a5, 15, 1);
        pulses = 0;
        for (int i = PAT_W - 1; i >= 0; i--) bitin(a5[i]);
        chk("len15_pulses", 32'(pulses), 32'd1);
        chk("len15_last", 32'(data_out), 32'd1);

        // Counter saturation and clear
        cfg(8'b1, 1, 1);
        step(1, 0, 0, 0, '0, 0, 0, 1);
        repeat (5) bitin(1);
`ifdef SEQDET_COUNT_EN
        chk("cnt_sat", 32'(match_cnt), 32'd3);
`endif
        step(1, 1, 1, 0, '0, 0, 0, 1);
`ifdef SEQDET_COUNT_EN
        chk("cnt_clr_hit", 32'(match_cnt), 32'd1);
`endif
        step(1, 0, 0, 0, '0, 0, 0, 1);
`ifdef SEQDET_COUNT_EN
        chk("cnt_clr_only", 32'(match_cnt), 32'd0);
`endif

        // Reset mid-pattern: next match needs a full fresh pattern
        step(0, 0, 0, 0, '0, 0, 0, 0);
        cfg(8'b10110, 5, 1);
        bitin(1); bitin(0); bitin(1);
        step(0, 1, 1, 0, '0, 0, 0, 0);
        chk("rst_mid_out", 32'(data_out), 32'd0);
        chk("rst_mid_cnt", 32'(match_cnt), 32'd0);
        cfg(8'b10110, 5, 1);
        pulses = 0;
        bitin(1); bitin(0);
        chk("rst_mid_partial", 32'(pulses), 32'd0);
        foreach (gap_pat[i]) bitin(gap_pat[i]);
        chk("rst_mid_full", 32'(pulses), 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            bit r, v, d, ld, o, clr;
            int l;
            r   = ($urandom_range(0, 79) != 0);
            ld  = ($urandom_range(0, 24) == 0);
            v   = ($urandom_range(0, 3) != 0);
            d   = 1'($urandom);
            o   = 1'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            l   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4);
            step(r, v, d, ld, PAT_W'($urandom), l, o, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
